// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential unsigned divider:
//   - div_state_e   : controller states (IDLE, CALC, DONE)
//   - MAX_WIDTH     : widest operand the divider is built for
//   - DIV0_QUOTIENT : quotient reported for a zero divisor (all ones),
//                     sliced down to the instance width by the user
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/eight_bit_adder.sv
// -----------------------------------------------------------------------------
// eight_bit_adder
// Parameterised ripple-style adder with carry in/out. Despite the historical
// name the width is set by WIDTH. The divider uses it as a subtractor by
// feeding the inverted subtrahend with ci_i = 1; co_o = 1 then means "no
// borrow".
//
// Ports:
//   a_i   [WIDTH-1:0]  first addend
//   b_i   [WIDTH-1:0]  second addend
//   ci_i               carry in
//   s_o   [WIDTH-1:0]  sum
//   co_o               carry out
// -----------------------------------------------------------------------------
module eight_bit_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    output logic [WIDTH-1:0] s_o,
    output logic             co_o
);

    logic [WIDTH:0] full_sum;

    always_comb begin
        full_sum = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, ci_i};
    end

    assign s_o  = full_sum[WIDTH-1:0];
    assign co_o = full_sum[WIDTH];

endmodule

// File: rtl/seq_unsigned_divider.sv
// -----------------------------------------------------------------------------
// seq_unsigned_divider
// Sequential restoring divider: one quotient bit per clock. A start accepted
// in IDLE latches the operands; WIDTH CALC cycles later a one-cycle done
// pulse presents the quotient and remainder, which then hold until the next
// operation completes. A zero divisor skips CALC and reports quotient =
// all ones, remainder = dividend, div_by_zero = 1. WIDTH must lie in 2..16.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start        request a divide (sampled only in IDLE)
//   dividend     [WIDTH-1:0] numerator, captured on accepted start
//   divisor      [WIDTH-1:0] denominator, captured on accepted start
//   busy         high during CALC
//   done         one-cycle pulse, results valid
//   quotient     [WIDTH-1:0] result, held between operations
//   remainder    [WIDTH-1:0] result, held between operations
//   div_by_zero  set with done when the divisor was zero
// -----------------------------------------------------------------------------
module seq_unsigned_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Controller and datapath state
    div_state_e       state_q;
    logic [WIDTH-1:0] div_q;       // latched divisor
    logic [WIDTH-1:0] rem_q;       // partial remainder
    logic [WIDTH-1:0] quo_q;       // dividend bits shifting out, quotient bits in
    logic [CNT_W-1:0] cnt_q;       // iterations still to run
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    // One restoring iteration, computed from the current state
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic             trial_msb_unused;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [CNT_W-1:0] cnt_d;
    logic             last_iter;

    // shifted - {0, div_q} as shifted + ~{0, div_q} + 1; the carry out is the
    // "shifted >= divisor" decision.
    eight_bit_adder #(
        .WIDTH (WIDTH + 1)
    ) u_trial_sub (
        .a_i  (shifted),
        .b_i  (~{1'b0, div_q}),
        .ci_i (1'b1),
        .s_o  (trial),
        .co_o (no_borrow)
    );

    // Because rem_q < divisor holds between iterations, a successful trial
    // always fits in WIDTH bits, so the sum MSB carries no information.
    assign trial_msb_unused = trial[WIDTH];

    always_comb begin
        // NOTE: every always_comb output gets a value on every path; assigning
        // all of them unconditionally here keeps the block free of latches.
        shifted   = {rem_q, quo_q[WIDTH-1]};
        rem_d     = no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], no_borrow};
        cnt_d     = cnt_q - CNT_W'(1);
        last_iter = (cnt_q == CNT_W'(1));
    end

    // NOTE: the datapath registers are reset along with the controller so an
    // aborted divide leaves no stale operands visible in simulation or scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples pre-edge values regardless of order.
            done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            div_q   <= divisor;
                            rem_q   <= '0;
                            quo_q   <= dividend;
                            cnt_q   <= CNT_W'(WIDTH);
                            dbz_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end else begin
                            // Zero divisor: publish the fixed result at once.
                            quo_q       <= DIV0_QUOTIENT[WIDTH-1:0];
                            rem_q       <= dividend;
                            quotient_q  <= DIV0_QUOTIENT[WIDTH-1:0];
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end

                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_d;
                    if (last_iter) begin
                        // Outputs only update here, so they stay stable in CALC.
                        quotient_q  <= quo_d;
                        remainder_q <= rem_d;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
